// File: rtl/trdb_pkg.sv
// Shared packet encodings and FSM state type for the trace-debugger timestamp packetizer.
package trdb_pkg;

    localparam logic [1:0] TRDB_FMT_TIMER     = 2'b11;
    localparam logic [1:0] TRDB_SF_TIME_ABS   = 2'b00;
    localparam logic [1:0] TRDB_SF_TIME_DELTA = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/trdb_nibble_len.sv
// Combinational count of significant nibbles in a value (highest non-zero nibble index + 1, minimum 1).
module trdb_nibble_len #(
    parameter int unsigned WIDTH       = 40,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic [WIDTH-1:0]       value_i,
    output logic [COUNT_WIDTH-1:0] count_o
);

    localparam int unsigned NIBBLES = (WIDTH + 3) / 4;

    logic [NIBBLES*4-1:0] padded;
    logic [NIBBLES-1:0]   nonzero;

    assign padded = (NIBBLES*4)'(value_i);

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nibble
            assign nonzero[gi] = |padded[gi*4 +: 4];
        end
    endgenerate

    // Later nibbles overwrite earlier ones, so the highest non-zero nibble wins.
    always_comb begin
        count_o = COUNT_WIDTH'(1);
        for (int i = 0; i < NIBBLES; i++) begin
            if (nonzero[i]) begin
                count_o = COUNT_WIDTH'(i + 1);
            end
        end
    end

endmodule

// File: rtl/trdb_timestamp_packetizer.sv
// Snapshots the timer on a granted request and holds one formatted timer packet for the packet stream.
// Optional macro TRDB_TIME_DELTA_EN: encode timestamps relative to the last delivered one.
module trdb_timestamp_packetizer
    import trdb_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH  = 40,
    parameter int unsigned PACKET_WIDTH = 64,
    parameter int unsigned LEN_WIDTH    = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic                    tu_valid_i,
    output logic                    tu_grant_o,
    input  logic [TIMER_WIDTH-1:0]  trdb_time_i,
    output logic                    packet_valid_o,
    input  logic                    packet_ready_i,
    output logic [PACKET_WIDTH-1:0] packet_o,
    output logic [LEN_WIDTH-1:0]    packet_len_o
);

    localparam int unsigned ABS_LEN = TIMER_WIDTH + 4;

    pkt_state_e              state_q, state_d;
    logic [PACKET_WIDTH-1:0] packet_q, packet_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    grant;
    logic                    accept;
    logic [1:0]              subformat;
    logic [TIMER_WIDTH-1:0]  payload;
    logic [LEN_WIDTH-1:0]    payload_len;

`ifdef TRDB_TIME_DELTA_EN
    localparam int unsigned NIBBLES     = (TIMER_WIDTH + 3) / 4;
    localparam int unsigned COUNT_WIDTH = $clog2(NIBBLES + 1);

    logic                   base_valid_q, base_valid_d;
    logic [TIMER_WIDTH-1:0] base_q, base_d;
    logic [TIMER_WIDTH-1:0] snap_q, snap_d;
    logic [TIMER_WIDTH-1:0] delta;
    logic [COUNT_WIDTH-1:0] nibbles;

    // Modular subtraction makes timer wrap-around transparent.
    assign delta = trdb_time_i - base_q;

    trdb_nibble_len #(
        .WIDTH       (TIMER_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_nibble_len (
        .value_i (delta),
        .count_o (nibbles)
    );

    always_comb begin
        if (base_valid_q) begin
            subformat   = TRDB_SF_TIME_DELTA;
            payload     = delta;
            payload_len = LEN_WIDTH'(4 + 4 * int'(nibbles));
        end else begin
            subformat   = TRDB_SF_TIME_ABS;
            payload     = trdb_time_i;
            payload_len = LEN_WIDTH'(ABS_LEN);
        end
    end

    // The base tracks the last delivered snapshot, so it only moves on acceptance.
    always_comb begin
        base_valid_d = base_valid_q;
        base_d       = base_q;
        snap_d       = snap_q;
        if (clear_i) begin
            base_valid_d = 1'b0;
        end else if (accept) begin
            base_valid_d = 1'b1;
            base_d       = snap_q;
        end else if (grant) begin
            snap_d = trdb_time_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_valid_q <= 1'b0;
            base_q       <= '0;
            snap_q       <= '0;
        end else begin
            base_valid_q <= base_valid_d;
            base_q       <= base_d;
            snap_q       <= snap_d;
        end
    end
`else
    assign subformat   = TRDB_SF_TIME_ABS;
    assign payload     = trdb_time_i;
    assign payload_len = LEN_WIDTH'(ABS_LEN);
`endif

    // Grant is combinational; gating with rst_ni keeps it low while reset is asserted.
    always_comb begin
        grant    = rst_ni && (state_q == IDLE) && tu_valid_i && enable_i && !clear_i;
        accept   = (state_q == FULL) && packet_ready_i;
        state_d  = state_q;
        packet_d = packet_q;
        len_d    = len_q;
        if (clear_i) begin
            state_d  = IDLE;
            packet_d = '0;
            len_d    = '0;
        end else if (accept) begin
            state_d = IDLE;
        end else if (grant) begin
            state_d                   = FULL;
            packet_d                  = '0;
            packet_d[1:0]             = TRDB_FMT_TIMER;
            packet_d[3:2]             = subformat;
            packet_d[TIMER_WIDTH+3:4] = payload;
            len_d                     = payload_len;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            packet_q <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            packet_q <= packet_d;
            len_q    <= len_d;
        end
    end

    assign tu_grant_o     = grant;
    assign packet_valid_o = (state_q == FULL);
    assign packet_o       = packet_q;
    assign packet_len_o   = len_q;

endmodule
